// File: rtl/tt_um_uio_loopback_checker_if.sv
// Pin bundle for the Tiny Tapeout uio loopback checker.
// Groups the dedicated inputs, dedicated outputs and the bidirectional
// uio pad signals so that the checker and its environment share one port.
//   ui_in   : control inputs (start, mode, continuous, view select)
//   uo_out  : status or captured read-back value
//   uio_in  : read-back path from the pads
//   uio_out : pattern drive towards the pads
//   uio_oe  : pad output enables (all on while driving)
//   ena     : power-good indication, not used by the checker
// The slave modport is the checker itself; the master modport is the
// environment that drives the controls and the read-back path.
`timescale 1ns/1ps

interface tt_um_uio_loopback_checker_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in,
        output uio_in,
        output ena,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        input  ena,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_uio_loopback_checker.sv
// Self-test for the bidirectional uio pads.
// A run drives a sequence of patterns out on uio_out with uio_oe all on,
// waits SETTLE cycles, samples uio_in for one cycle, then releases the bus
// for TURNAROUND cycles before the next pattern. Read-back mismatches are
// counted in a 4-bit saturating counter and raise a sticky fail flag.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears all state and releases the bus
//   bus   : pin bundle (slave side)
//             ui_in[0] start (rising edge), ui_in[1] mode (0 walking one,
//             1 LFSR), ui_in[2] continuous, ui_in[3] view select
//             uo_out view 0 = {err_count, fail, pass, done, busy}
//             uo_out view 1 = last captured uio_in
`timescale 1ns/1ps

module tt_um_uio_loopback_checker #(
    parameter int SETTLE     = 4,
    parameter int TURNAROUND = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    tt_um_uio_loopback_checker_if.slave  bus
);

    localparam int MAX_CNT = (SETTLE > TURNAROUND) ? SETTLE : TURNAROUND;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST     = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TURNAROUND_LAST = CNT_W'(TURNAROUND - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        RELEASE,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [3:0]       idx, idx_next;
    logic [7:0]       pattern, pattern_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       err_count, err_next;
    logic             fail, fail_next;
    logic [7:0]       last_cap, cap_next;
    logic             mode, mode_next;
    logic [7:0]       drive_out, drive_oe;
    logic [7:0]       out_next, oe_next;
    logic             sync1, sync2, sync3;
    logic             start_pulse;
    logic             restart;
    logic             driving_next;
    logic [7:0]       lfsr_next;
    logic [3:0]       last_idx;
    logic             busy, done, pass;
    logic             unused_inputs;

    // ena and the spare control pins carry no function here.
    assign unused_inputs = &{1'b0, bus.ena, bus.ui_in[7:4]};

    // The start pin is asynchronous to clk: two flops resolve
    // metastability, the third delays it so only the rising edge fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.ui_in[0];
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_pulse = sync2 & ~sync3;
    assign lfsr_next   = {pattern[6:0], pattern[7] ^ pattern[5] ^ pattern[4] ^ pattern[3]};
    assign last_idx    = mode ? 4'd15 : 4'd7;

    // Next-state logic. A restart (from IDLE, or from DONE by a start edge or
    // continuous mode) is handled once at the end so a simultaneous start
    // edge and continuous request still give a single restart.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        pattern_next = pattern;
        cnt_next     = cnt;
        err_next     = err_count;
        fail_next    = fail;
        cap_next     = last_cap;
        mode_next    = mode;
        restart      = 1'b0;

        case (state)
            IDLE: begin
                restart = start_pulse;
            end
            DRIVE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                cap_next = bus.uio_in;
                if (bus.uio_in != pattern) begin
                    fail_next = 1'b1;
                    if (err_count != 4'hF) begin
                        err_next = err_count + 4'd1;
                    end
                end
                cnt_next   = '0;
                state_next = RELEASE;
            end
            RELEASE: begin
                if (cnt == TURNAROUND_LAST) begin
                    cnt_next = '0;
                    if (idx == last_idx) begin
                        state_next = DONE;
                    end else begin
                        idx_next     = idx + 4'd1;
                        pattern_next = mode ? lfsr_next : {pattern[6:0], 1'b0};
                        state_next   = DRIVE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                restart = bus.ui_in[2] | start_pulse;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (restart) begin
            state_next   = DRIVE;
            idx_next     = 4'd0;
            pattern_next = 8'h01;
            cnt_next     = '0;
            err_next     = 4'd0;
            mode_next    = bus.ui_in[1];
        end
    end

    // Pad drive is computed from the next state so that uio_out and uio_oe
    // come straight from flops and switch together on the same edge.
    always_comb begin
        driving_next = (state_next == DRIVE) || (state_next == SAMPLE);
        oe_next      = driving_next ? 8'hFF : 8'h00;
        out_next     = driving_next ? pattern_next : 8'h00;
    end

    // All run state; the asynchronous reset releases the pads immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            pattern   <= 8'h00;
            cnt       <= '0;
            err_count <= 4'd0;
            fail      <= 1'b0;
            last_cap  <= 8'h00;
            mode      <= 1'b0;
            drive_out <= 8'h00;
            drive_oe  <= 8'h00;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            pattern   <= pattern_next;
            cnt       <= cnt_next;
            err_count <= err_next;
            fail      <= fail_next;
            last_cap  <= cap_next;
            mode      <= mode_next;
            drive_out <= out_next;
            drive_oe  <= oe_next;
        end
    end

    assign busy = (state == DRIVE) || (state == SAMPLE) || (state == RELEASE);
    assign done = (state == DONE);
    assign pass = done & (err_count == 4'd0);

    assign bus.uio_out = drive_out;
    assign bus.uio_oe  = drive_oe;
    assign bus.uo_out  = bus.ui_in[3] ? last_cap : {err_count, fail, pass, done, busy};

endmodule

// File: tb/tb_tt_um_uio_loopback_checker.sv
// Testbench for tt_um_uio_loopback_checker.
// Stimulus tasks queue the expected pattern/status events of each run; a
// negedge monitor pops an entry whenever the checker starts driving a new
// pattern or enters DONE, and compares it with what the pins show.
`timescale 1ns/1ps

module tb_tt_um_uio_loopback_checker;

    logic clk;
    logic rst_n;
    logic [7:0] in_mask;

    tt_um_uio_loopback_checker_if bus ();

    tt_um_uio_loopback_checker #(.SETTLE(4), .TURNAROUND(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Loopback: pads read back what is driven, with some bits optionally stuck low.
    assign bus.uio_in = (bus.uio_oe == 8'hFF) ? (bus.uio_out & in_mask) : 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         is_done;
        logic [7:0] pat;
        bit         has_uo;
        logic [7:0] uo;
        int         dur;
        bit         after_done;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    logic [7:0] lfsr_tab [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                                  8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25};

    // Single comparison point shared by the directed checks and the monitor.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Generate a synchronised start edge by holding ui_in[0] high for a few cycles.
    task automatic pulseStart();
        @(posedge clk); #1;
        bus.ui_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.ui_in[0] = 1'b0;
    endtask

    // Queue the expected events for nruns runs (npat patterns each) and start.
    task automatic applyStimulus(input bit mode, input bit cont, input logic [7:0] mask,
                                 input int nruns, input int npat,
                                 input logic [7:0] first_uo, input logic [7:0] later_uo,
                                 input logic [7:0] done_uo);
        exp_t it;
        int full;
        full = mode ? 16 : 8;
        in_mask = mask;
        bus.ui_in[1] = mode;
        bus.ui_in[2] = cont;
        for (int r = 0; r < nruns; r++) begin
            for (int i = 0; i < npat; i++) begin
                it.is_done    = 1'b0;
                it.pat        = mode ? lfsr_tab[i] : (8'h01 << i);
                it.has_uo     = (i == 0);
                it.uo         = (r == 0) ? first_uo : later_uo;
                it.dur        = 0;
                it.after_done = (i == 0) && (r > 0);
                exp_q.push_back(it);
            end
            if (npat == full) begin
                it.is_done    = 1'b1;
                it.pat        = 8'h00;
                it.has_uo     = 1'b1;
                it.uo         = done_uo;
                it.dur        = mode ? 112 : 56;
                it.after_done = 1'b0;
                exp_q.push_back(it);
            end
        end
        pulseStart();
    endtask

    // Wait until every queued event is consumed and the checker sits in DONE.
    task automatic waitDone(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && bus.uo_out[1]) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL wait_done actual=timeout required=done within %0d cycles", budget);
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor state
    int   cyc = 0;
    logic [7:0] prev_oe = 8'h00;
    int   drive_len = 0;
    int   gap_len = 0;
    bit   prev_done = 1'b0;
    bit   prev_busy = 1'b0;
    int   run_start = 0;
    int   done_cyc = 0;

    // Scoreboard monitor, sampling on the falling edge away from updates.
    always @(negedge clk) begin
        exp_t it;
        cyc++;
        if (!rst_n) begin
            prev_oe   = 8'h00;
            drive_len = 0;
            gap_len   = 0;
            prev_done = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (bus.uio_oe != 8'hFF) begin
                checkOutput("oe_off_levels", bus.uio_oe, 8'h00);
                checkOutput("out_zero_when_released", bus.uio_out, 8'h00);
            end
            if (bus.uio_oe == 8'hFF && prev_oe != 8'hFF) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_pattern actual=%h required=no drive", bus.uio_out);
                end else begin
                    it = exp_q.pop_front();
                    checkOutput("event_is_pattern", {7'd0, it.is_done}, 8'h00);
                    checkOutput("pattern", bus.uio_out, it.pat);
                    if (it.has_uo) checkOutput("run_start_status", bus.uo_out, it.uo);
                    if (it.after_done) checkOutput("done_to_drive", 8'(cyc - done_cyc), 8'd1);
                    if (gap_len > 0) checkOutput("release_gap", 8'(gap_len), 8'd2);
                end
                gap_len = 0;
                if (!prev_busy) run_start = cyc;
            end
            if (bus.uio_oe == 8'hFF) drive_len++;
            if (bus.uio_oe != 8'hFF && prev_oe == 8'hFF) begin
                checkOutput("drive_length", 8'(drive_len), 8'd5);
                drive_len = 0;
            end
            if (!bus.ui_in[3]) begin
                if (bus.uio_oe != 8'hFF && bus.uo_out[0]) gap_len++;
                if (bus.uo_out[1] && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_done actual=%h required=no done", bus.uo_out);
                    end else begin
                        it = exp_q.pop_front();
                        checkOutput("event_is_done", {7'd0, it.is_done}, 8'h01);
                        checkOutput("done_status", bus.uo_out, it.uo);
                        checkOutput("run_length", 8'(cyc - run_start), 8'(it.dur));
                    end
                    done_cyc = cyc;
                    gap_len  = 0;
                end
                prev_done = bus.uo_out[1];
                prev_busy = bus.uo_out[0];
            end
            prev_oe = bus.uio_oe;
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        rst_n      = 1'b0;
        bus.ui_in  = 8'hFF;
        bus.ena    = 1'b1;
        in_mask    = 8'hFF;

        // Reset holds everything low even with all controls high.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_uo_out", bus.uo_out, 8'h00);
        checkOutput("reset_uio_oe", bus.uio_oe, 8'h00);
        checkOutput("reset_uio_out", bus.uio_out, 8'h00);
        bus.ui_in = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_uo_out", bus.uo_out, 8'h00);

        // Mode 0 clean loopback.
        $display("[TB] mode 0 full loopback");
        applyStimulus(1'b0, 1'b0, 8'hFF, 1, 8, 8'h01, 8'h01, 8'h06);
        waitDone(200);
        checkOutput("mode0_final", bus.uo_out, 8'h06);

        // Mode 0 with bit 3 stuck low.
        $display("[TB] stuck bit 3");
        applyStimulus(1'b0, 1'b0, 8'hF7, 1, 8, 8'h01, 8'h01, 8'h1A);
        waitDone(200);
        checkOutput("stuck_final", bus.uo_out, 8'h1A);
        bus.ui_in[3] = 1'b1;
        #1;
        checkOutput("stuck_view1", bus.uo_out, 8'h80);
        bus.ui_in[3] = 1'b0;

        // Mode 1 LFSR, fail still set from the stuck run; mode pin flips mid-run.
        $display("[TB] mode 1 LFSR");
        applyStimulus(1'b1, 1'b0, 8'hFF, 1, 16, 8'h09, 8'h09, 8'h0E);
        repeat (10) @(posedge clk);
        #1;
        bus.ui_in[1] = 1'b0;
        waitDone(300);
        checkOutput("mode1_final", bus.uo_out, 8'h0E);

        doReset();
        #1;
        checkOutput("after_reset_uo", bus.uo_out, 8'h00);

        // Second start edge while busy is ignored.
        $display("[TB] start while busy");
        applyStimulus(1'b0, 1'b0, 8'hFF, 1, 8, 8'h01, 8'h01, 8'h06);
        repeat (15) @(posedge clk);
        pulseStart();
        waitDone(200);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy_start_final", bus.uo_out, 8'h06);
        checkOutput("busy_start_queue", 8'(exp_q.size()), 8'd0);

        // Asynchronous reset during the third pattern.
        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 1'b0, 8'hFF, 1, 3, 8'h01, 8'h01, 8'h00);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            if (bus.uio_oe == 8'hFF && bus.uio_out == 8'h04) seen = 1'b1;
        end
        checkOutput("reach_pattern3", {7'd0, seen}, 8'h01);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_oe", bus.uio_oe, 8'h00);
        checkOutput("async_reset_out", bus.uio_out, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_uo", bus.uo_out, 8'h00);
        checkOutput("post_reset_oe", bus.uio_oe, 8'h00);
        checkOutput("post_reset_queue", 8'(exp_q.size()), 8'd0);
        applyStimulus(1'b0, 1'b0, 8'hFF, 1, 8, 8'h01, 8'h01, 8'h06);
        waitDone(200);

        // Continuous mode with every read-back bit stuck low, two runs.
        $display("[TB] continuous mode");
        applyStimulus(1'b0, 1'b1, 8'h00, 2, 8, 8'h01, 8'h09, 8'h8A);
        repeat (80) @(posedge clk);
        #1;
        bus.ui_in[2] = 1'b0;
        waitDone(300);
        checkOutput("continuous_final", bus.uo_out, 8'h8A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
